// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with built-in baud divider and
// a first-word-fall-through transmit FIFO behind a valid/ready write port.
// Frames are: start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Each bit lasts DIV = CLK_FREQ/BAUD_RATE clocks.
// Queued words drain back-to-back with no idle gap between frames.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    word to transmit (sampled only when accepted)
//   in_valid   in_data is valid
//   in_ready   FIFO can accept a word (not full)
//   fifo_level number of words currently held in the FIFO
//   busy       a frame is on the line
//   tx_done    one-cycle pulse during the final clock of each frame
//   uart_tx    registered serial line, idle high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          uart_tx
);

  localparam int DIV      = CLK_FREQ / BAUD_RATE;
  localparam int STOP_LEN = STOP_BITS * DIV;
  localparam int CNT_W    = $clog2(STOP_LEN);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity of the word being framed; mark/space ignore the data.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    case (PARITY)
      1:       p = ~(^d);
      2:       p = ^d;
      3:       p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;

  // Transmit state
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_baud;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_head;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = in_valid && !w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_bit_end  = (r_baud == CNT_W'(DIV - 1));
  assign w_stop_end = (r_baud == CNT_W'(STOP_LEN - 1));

  // A pop happens when the line is free to start a new frame: from IDLE, or
  // on the last clock of the stop period so the next start bit follows
  // without a gap.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

  assign in_ready   = !w_full;
  assign fifo_level = r_count;
  assign busy       = (r_state != S_IDLE);
  assign tx_done    = r_done;
  assign uart_tx    = r_tx;

  // FIFO storage is data only; no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_head;
            r_par   <= calc_parity(w_head);
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // r_shift[0] is always the bit currently on the line, so the next
        // bit to drive is r_shift[1] before the shift.
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // Stop period spans all stop bits in one count. tx_done is set one
        // clock early so that it is high during the final stop clock.
        S_STOP: begin
          if (w_stop_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
              r_par   <= calc_parity(w_head);
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
            if (r_baud == CNT_W'(STOP_LEN - 2)) begin
              r_done <= 1'b1;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_baud  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Six instances at DIV=10: 8N1 with a 4-deep
// FIFO, four 8-bit parity variants (odd/even/mark/space) and a 7E2 format.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [5:0] vld;
  logic [5:0] rdy;
  logic [5:0] bsy;
  logic [5:0] done;
  logic [5:0] tx;
  logic [2:0] lvl0;
  logic [4:0] lvlx [1:5];

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vld[0]),
    .in_ready(rdy[0]), .fifo_level(lvl0), .busy(bsy[0]),
    .tx_done(done[0]), .uart_tx(tx[0])
  );

  for (genvar g = 1; g <= 4; g++) begin : g_par
    uart_tx_fifo #(
      .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
      .PARITY(g), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u (
      .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vld[g]),
      .in_ready(rdy[g]), .fifo_level(lvlx[g]), .busy(bsy[g]),
      .tx_done(done[g]), .uart_tx(tx[g])
    );
  end

  uart_tx_fifo #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(din[6:0]), .in_valid(vld[5]),
    .in_ready(rdy[5]), .fifo_level(lvlx[5]), .busy(bsy[5]),
    .tx_done(done[5]), .uart_tx(tx[5])
  );

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [15:0] bits;   // expected line value per bit slot, slot 0 = start
    int          nbits;
    string       name;
  } vec_t;

  vec_t tbl [12];

  // Stream sequence description on u0
  logic [7:0] sw [6];
  int         se [6];   // earliest cycle a word may be offered
  int         sp [6];   // expected acceptance cycle
  int         sa [6];   // observed acceptance cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic bit8n1(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Single frame on one instance; called one tick after a rising edge.
  task automatic run_vec(input vec_t v);
    int nd;
    int last;
    logic e;
    last = 10 * v.nbits;
    din = v.data;
    vld[v.sel] = 1'b1;
    @(posedge clk); #1;
    vld = '0;
    chk($sformatf("%s tx c0", v.name), {31'd0, tx[v.sel]}, 32'd1);
    chk($sformatf("%s busy c0", v.name), {31'd0, bsy[v.sel]}, 32'd0);
    nd = 0;
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk); #1;
      e = (c <= last) ? v.bits[(c-1)/10] : 1'b1;
      if (done[v.sel]) nd++;
      chk($sformatf("%s tx c%0d", v.name, c), {31'd0, tx[v.sel]}, {31'd0, e});
      chk($sformatf("%s done c%0d", v.name, c), {31'd0, done[v.sel]}, {31'd0, c == last});
      chk($sformatf("%s busy c%0d", v.name, c), {31'd0, bsy[v.sel]}, {31'd0, c <= last});
    end
    chk($sformatf("%s done_count", v.name), nd, 1);
  endtask

  // Stream of n 8N1 frames on u0, checked every cycle against a timeline
  // where frame f starts the cycle after edge 1+100f.
  task automatic run_stream(input string nm, input int n);
    int idx;
    int pushes;
    int pops;
    int el;
    logic v_now;
    logic r_now;
    logic e;
    idx = 0;
    for (int i = 0; i < 6; i++) sa[i] = -1;
    for (int c = 0; c <= 100 * n + 2; c++) begin
      if (idx < n && c >= se[idx]) begin
        din = sw[idx];
        vld[0] = 1'b1;
      end else begin
        vld[0] = 1'b0;
      end
      v_now = vld[0];
      r_now = rdy[0];
      @(posedge clk); #1;
      if (v_now && r_now) begin
        sa[idx] = c;
        idx++;
      end
      pushes = 0;
      pops = 0;
      for (int i = 0; i < n; i++) begin
        if (sp[i] <= c) pushes++;
        if (1 + 100 * i <= c) pops++;
      end
      el = pushes - pops;
      if (c >= 1 && c <= 100 * n) e = bit8n1(sw[(c-1)/100], ((c-1) % 100) / 10);
      else e = 1'b1;
      chk($sformatf("%s level c%0d", nm, c), {29'd0, lvl0}, el);
      chk($sformatf("%s ready c%0d", nm, c), {31'd0, rdy[0]}, {31'd0, el < 4});
      chk($sformatf("%s tx c%0d", nm, c), {31'd0, tx[0]}, {31'd0, e});
      chk($sformatf("%s busy c%0d", nm, c), {31'd0, bsy[0]},
          {31'd0, (c >= 1 && c <= 100 * n)});
      chk($sformatf("%s done c%0d", nm, c), {31'd0, done[0]},
          {31'd0, (c >= 100 && c <= 100 * n && (c % 100) == 0)});
    end
    vld[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s accept_cycle%0d", nm, i), sa[i], sp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    vld    = '0;
    din    = '0;
    rst_n  = 1'b0;

    tbl[0]  = '{0, 8'hA5, 16'h034A, 10, "8N1_A5"};
    tbl[1]  = '{0, 8'h3C, 16'h0278, 10, "8N1_3C"};
    tbl[2]  = '{1, 8'hA5, 16'h074A, 11, "odd_A5"};
    tbl[3]  = '{2, 8'hA5, 16'h054A, 11, "even_A5"};
    tbl[4]  = '{3, 8'hA5, 16'h074A, 11, "mark_A5"};
    tbl[5]  = '{4, 8'hA5, 16'h054A, 11, "space_A5"};
    tbl[6]  = '{1, 8'h07, 16'h040E, 11, "odd_07"};
    tbl[7]  = '{2, 8'h07, 16'h060E, 11, "even_07"};
    tbl[8]  = '{3, 8'h07, 16'h060E, 11, "mark_07"};
    tbl[9]  = '{4, 8'h07, 16'h040E, 11, "space_07"};
    tbl[10] = '{5, 8'h41, 16'h0682, 11, "7E2_41"};
    tbl[11] = '{5, 8'h7F, 16'h07FE, 11, "7E2_7F"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset tx", {26'd0, tx}, 32'h3F);
    chk("reset busy", {26'd0, bsy}, 32'h0);
    chk("reset done", {26'd0, done}, 32'h0);
    chk("reset ready", {26'd0, rdy}, 32'h3F);
    chk("reset level u0", {29'd0, lvl0}, 32'd0);
    chk("reset level u5", {27'd0, lvlx[5]}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i]);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back with a full 4-deep FIFO; the sixth word waits for a pop.
    sw = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    se = '{0, 0, 0, 0, 0, 0};
    sp = '{0, 1, 2, 3, 4, 102};
    run_stream("b2b", 6);
    repeat (3) @(posedge clk);
    #1;

    // Write landing on the same edge as a stop->start pop at level 1.
    sw = '{8'h81, 8'h42, 8'hC3, 8'h00, 8'h00, 8'h00};
    se = '{0, 1, 101, 0, 0, 0};
    sp = '{0, 1, 101, 0, 0, 0};
    run_stream("simul", 3);
    repeat (3) @(posedge clk);
    #1;

    // Reset during data bit 3 of 0x11 with two words queued behind it.
    din = 8'h11; vld[0] = 1'b1;
    @(posedge clk); #1; din = 8'h22;
    @(posedge clk); #1; din = 8'h33;
    @(posedge clk); #1; vld[0] = 1'b0;
    repeat (42) @(posedge clk);
    #1;
    chk("midrst pre tx", {31'd0, tx[0]}, 32'd0);
    chk("midrst pre level", {29'd0, lvl0}, 32'd2);
    chk("midrst pre busy", {31'd0, bsy[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst tx", {31'd0, tx[0]}, 32'd1);
    chk("midrst busy", {31'd0, bsy[0]}, 32'd0);
    chk("midrst level", {29'd0, lvl0}, 32'd0);
    chk("midrst ready", {31'd0, rdy[0]}, 32'd1);
    chk("midrst done", {31'd0, done[0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst idle tx c%0d", c), {31'd0, tx[0]}, 32'd1);
      chk($sformatf("postrst idle busy c%0d", c), {31'd0, bsy[0]}, 32'd0);
      chk($sformatf("postrst idle level c%0d", c), {29'd0, lvl0}, 32'd0);
    end
    run_vec('{0, 8'h5A, 16'h02B4, 10, "postrst_5A"});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
